// File: rtl/key_pkg.sv
// Shared types for the keypad event path: key count, code width and the event
// record that travels from the scanner front end to the consumers.
package key_pkg;

  localparam int NUM_KEYS = 16;
  localparam int KEY_W    = 4;

  typedef struct packed {
    logic             is_release;
    logic [KEY_W-1:0] code;
  } key_event_t;

  // row*4+col for a 4x4 matrix is just the two fields concatenated.
  function automatic logic [KEY_W-1:0] key_code(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/key_fifo.sv
// First-word fall-through FIFO for key events; head is visible while not empty
// and the output reads as zero when the queue is empty.
module key_fifo
  import key_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = key_event_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  T                         i_data,
  input  logic                     i_pop,
  output T                         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  T              r_mem [DEPTH];

  logic w_do_push;
  logic w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_level   = r_count;
  assign w_do_pop  = i_pop && !o_empty;
  // A push into a full queue is legal when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = o_empty ? T'('0) : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/key_event_queue.sv
// Turns debounced key levels into an ordered press/release event stream:
// synchroniser, edge detect, pending masks, fixed-priority arbiter, FIFO.
module key_event_queue
  import key_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter bit REPORT_RELEASE = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_KEYS-1:0]      btn,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [KEY_W-1:0]         out_code,
  output logic                     out_release,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
);

  logic [NUM_KEYS-1:0] r_s1, r_s2, r_prev;
  logic [NUM_KEYS-1:0] r_pend_p, r_pend_r;
  logic                r_overflow;

  logic [NUM_KEYS-1:0] w_press_edge, w_rel_edge;
  logic [NUM_KEYS-1:0] w_clr_p, w_clr_r;
  logic                w_full, w_empty, w_pop, w_can_accept;
  logic                w_sel_valid, w_sel_rel;
  logic [KEY_W-1:0]    w_sel_code;
  key_event_t          w_push_ev, w_head;

  assign w_press_edge = r_s2 & ~r_prev;
  assign w_rel_edge   = REPORT_RELEASE ? (~r_s2 & r_prev) : '0;

  // Handshake: the head event transfers on any rising clk edge where
  // out_valid && out_ready; the head stays stable until that transfer.
  assign out_valid    = !w_empty;
  assign w_pop        = out_valid && out_ready;
  assign w_can_accept = !w_full || w_pop;

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_rel   = 1'b0;
    w_sel_code  = '0;
    w_clr_p     = '0;
    w_clr_r     = '0;
    // Presses always win so a key's press is queued ahead of its release.
    if (w_can_accept) begin
      if (|r_pend_p) begin
        w_sel_valid = 1'b1;
        for (int i = NUM_KEYS-1; i >= 0; i--) if (r_pend_p[i]) w_sel_code = KEY_W'(i);
        w_clr_p[w_sel_code] = 1'b1;
      end else if (|r_pend_r) begin
        w_sel_valid = 1'b1;
        w_sel_rel   = 1'b1;
        for (int i = NUM_KEYS-1; i >= 0; i--) if (r_pend_r[i]) w_sel_code = KEY_W'(i);
        w_clr_r[w_sel_code] = 1'b1;
      end
    end
  end

  assign w_push_ev = '{is_release: w_sel_rel, code: w_sel_code};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1       <= '0;
      r_s2       <= '0;
      r_prev     <= '0;
      r_pend_p   <= '0;
      r_pend_r   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_s1     <= btn;
      r_s2     <= r_s1;
      r_prev   <= r_s2;
      // New edges override a same-cycle clear; re-setting a live bit drops an event.
      r_pend_p <= (r_pend_p & ~w_clr_p) | w_press_edge;
      r_pend_r <= (r_pend_r & ~w_clr_r) | w_rel_edge;
      if ((|(w_press_edge & r_pend_p & ~w_clr_p)) || (|(w_rel_edge & r_pend_r & ~w_clr_r)))
        r_overflow <= 1'b1;
    end
  end

  key_fifo #(.DEPTH(DEPTH), .T(key_event_t)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_sel_valid),
    .i_data  (w_push_ev),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  assign out_code    = w_head.code;
  assign out_release = w_head.is_release;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_key_event_queue.sv
// Self-checking bench for key_event_queue: scenario tasks plus a scoreboard
// of expected {release, code} events popped as the DUT hands them out.
module tb_key_event_queue;
  import key_pkg::*;

  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   btn = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [3:0]    out_code;
  logic          out_release;
  logic [LW-1:0] fifo_level;
  logic          overflow;

  logic [15:0]   btn2 = '0;
  logic          out_ready2 = 1'b1;
  logic          v2;
  logic [3:0]    code2;
  logic          rel2;
  logic [LW-1:0] level2;
  logic          ovf2;

  int total = 0;
  int bad   = 0;

  logic [4:0] exp_q[$];
  logic [4:0] exp2_q[$];
  logic [4:0] exp_ev;
  logic [4:0] exp2_ev;

  always #5 clk = ~clk;

  key_event_queue #(.DEPTH(DEPTH), .REPORT_RELEASE(1'b1)) dut (
    .clk(clk), .rst(rst), .btn(btn), .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code), .out_release(out_release), .fifo_level(fifo_level), .overflow(overflow)
  );

  key_event_queue #(.DEPTH(DEPTH), .REPORT_RELEASE(1'b0)) dut2 (
    .clk(clk), .rst(rst), .btn(btn2), .out_valid(v2), .out_ready(out_ready2),
    .out_code(code2), .out_release(rel2), .fifo_level(level2), .overflow(ovf2)
  );

  // Scoreboard for the release-reporting instance.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL event_unexpected got=%h exp=none", {out_release, out_code});
      end else begin
        exp_ev = exp_q.pop_front();
        if ({out_release, out_code} !== exp_ev) begin
          bad++;
          $display("FAIL event_order got=%h exp=%h", {out_release, out_code}, exp_ev);
        end
      end
    end
  end

  // Scoreboard for the press-only instance.
  always @(negedge clk) begin
    if (!rst && v2 && out_ready2) begin
      total++;
      if (exp2_q.size() == 0) begin
        bad++;
        $display("FAIL press_only_unexpected got=%h exp=none", {rel2, code2});
      end else begin
        exp2_ev = exp2_q.pop_front();
        if ({rel2, code2} !== exp2_ev) begin
          bad++;
          $display("FAIL press_only_order got=%h exp=%h", {rel2, code2}, exp2_ev);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({out_valid, out_release, out_code, fifo_level, overflow} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0", {out_valid, out_release, out_code, fifo_level, overflow});
    end
    total++;
    if ({v2, level2, ovf2} !== '0) begin
      bad++;
      $display("FAIL reset_outputs2 got=%h exp=0", {v2, level2, ovf2});
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_single_press();
    bit ok;
    out_ready = 1'b1;
    exp_q.push_back({1'b0, key_code(2'd1, 2'd1)});
    btn = 16'h0020;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL latency_early got=%b exp=0", out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_code !== 4'd5 || out_release !== 1'b0) begin
      bad++;
      $display("FAIL latency_valid got=%b/%0d/%b exp=1/5/0", out_valid, out_code, out_release);
    end
    wait_drain(20, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_press_drain got=%0d left exp=0", exp_q.size()); end
    exp_q.push_back({1'b1, 4'd5});
    btn = 16'h0000;
    wait_drain(20, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_release_drain got=%0d left exp=0", exp_q.size()); end
    total++;
    if (overflow !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_idle got=%b%b exp=00", overflow, out_valid);
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    logic [3:0] codes [3] = '{4'd0, 4'd8, 4'd15};
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) exp_q.push_back({1'b0, codes[k]});
    btn = 16'h8101;
    repeat (3) @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_code !== codes[k]) begin
        bad++;
        $display("FAIL simul_consecutive got=%b/%0d exp=1/%0d", out_valid, out_code, codes[k]);
      end
    end
    wait_drain(20, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL simul_drain got=%0d left exp=0", exp_q.size()); end
    for (int k = 0; k < 3; k++) exp_q.push_back({1'b1, codes[k]});
    btn = 16'h0000;
    wait_drain(20, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL simul_release_drain got=%0d left exp=0", exp_q.size()); end
  endtask

  task automatic test_back_pressure();
    bit ok;
    out_ready = 1'b0;
    for (int i = 1; i <= 10; i++) exp_q.push_back({1'b0, 4'(i)});
    btn = 16'h07FE;
    repeat (20) @(posedge clk);
    @(negedge clk);
    total++;
    if (fifo_level !== LW'(8) || overflow !== 1'b0 || out_code !== 4'd1) begin
      bad++;
      $display("FAIL bp_full got=%0d/%b/%0d exp=8/0/1", fifo_level, overflow, out_code);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL bp_drain got=%0d left exp=0", exp_q.size()); end
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) exp_q.push_back({1'b1, 4'(i)});
    btn = 16'h0000;
    wait_drain(40, ok);
    total++;
    if (!ok || overflow !== 1'b0) begin
      bad++;
      $display("FAIL bp_release got=%0d left ovf=%b exp=0 left ovf=0", exp_q.size(), overflow);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    out_ready = 1'b0;
    for (int i = 8; i <= 15; i++) exp_q.push_back({1'b0, 4'(i)});
    btn = 16'hFF00;
    repeat (15) @(posedge clk);
    @(negedge clk);
    total++;
    if (fifo_level !== LW'(8) || overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_fill got=%0d/%b exp=8/0", fifo_level, overflow);
    end
    @(posedge clk); #1 btn = 16'hFF08;
    repeat (4) @(posedge clk); #1 btn = 16'hFF00;
    repeat (4) @(posedge clk); #1 btn = 16'hFF08;
    repeat (6) @(negedge clk);
    total++;
    if (overflow !== 1'b1 || fifo_level !== LW'(8)) begin
      bad++;
      $display("FAIL ovf_set got=%b/%0d exp=1/8", overflow, fifo_level);
    end
    exp_q.push_back({1'b0, 4'd3});
    exp_q.push_back({1'b1, 4'd3});
    @(posedge clk); #1 out_ready = 1'b1;
    wait_drain(40, ok);
    total++;
    if (!ok || overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_drain got=%0d left ovf=%b exp=0 left ovf=1", exp_q.size(), overflow);
    end
    exp_q.push_back({1'b1, 4'd3});
    for (int i = 8; i <= 15; i++) exp_q.push_back({1'b1, 4'(i)});
    btn = 16'h0000;
    wait_drain(40, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL ovf_release got=%0d left exp=0", exp_q.size()); end
  endtask

  task automatic test_release_mask();
    exp2_q.push_back({1'b0, 4'd0});
    exp2_q.push_back({1'b0, 4'd4});
    btn2 = 16'h0011;
    repeat (10) @(posedge clk);
    #1 btn2 = 16'h0000;
    repeat (15) @(negedge clk);
    total++;
    if (exp2_q.size() != 0 || v2 !== 1'b0 || level2 !== '0 || ovf2 !== 1'b0) begin
      bad++;
      $display("FAIL release_mask got=%0d left v=%b lvl=%0d ovf=%b exp=0/0/0/0", exp2_q.size(), v2, level2, ovf2);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    @(posedge clk); #1;
    out_ready = 1'b0;
    btn = 16'h0244;
    repeat (10) @(posedge clk);
    @(negedge clk);
    total++;
    if (fifo_level !== LW'(3) || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL mid_queued got=%0d/%b exp=3/1", fifo_level, out_valid);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || fifo_level !== '0 || overflow !== 1'b0 || out_code !== '0) begin
      bad++;
      $display("FAIL mid_async_reset got=%b/%0d/%b/%0d exp=0/0/0/0", out_valid, fifo_level, overflow, out_code);
    end
    btn = 16'h0200;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.push_back({1'b0, 4'd9});
    out_ready = 1'b1;
    wait_drain(20, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL held_press got=%0d left exp=0", exp_q.size()); end
    repeat (10) @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || fifo_level !== '0) begin
      bad++;
      $display("FAIL held_single got=%b/%0d exp=0/0", out_valid, fifo_level);
    end
    @(posedge clk); #1;
    exp_q.push_back({1'b1, 4'd9});
    btn = 16'h0000;
    wait_drain(20, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL held_release got=%0d left exp=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_simultaneous();
    test_back_pressure();
    test_overflow();
    test_release_mask();
    test_reset_mid();
    repeat (5) @(posedge clk);
    total++;
    if (exp_q.size() != 0 || exp2_q.size() != 0) begin
      bad++;
      $display("FAIL leftover got=%0d/%0d exp=0/0", exp_q.size(), exp2_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_event_queue.md
# key_event_queue

Converts the 16 debounced key levels from the matrix keypad scanner into an ordered stream of press/release events with a valid/ready handshake. Sits directly downstream of the scanner, in the system clock domain, and feeds the consumer logic (display, calculator, FSMs). Each event carries a key code equal to the scanner's bit index: row*4+col.

## Interface
- DEPTH, 8: event FIFO depth, power of two, ≥2
- REPORT_RELEASE, 1: 1 = emit release events, 0 = press events only
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- btn  in  16  debounced key levels from the scanner; asynchronous to clk
- out_valid  out  1  head event available
- out_ready  in  1  consumer accepts head event
- out_code  out  4  key index 0–15 of head event
- out_release  out  1  head event is a release (0 = press)
- fifo_level  out  $clog2(DEPTH)+1  events queued
- overflow  out  1  sticky: an event was lost

## Operation
- **Synchroniser:** two-flop sync of btn → s2. prev register holds the previous s2.
- **Edge detect:**
  - press_edge = s2 & ~prev.
  - rel_edge = ~s2 & prev, masked to 0 when REPORT_RELEASE=0.
- **Pending masks:** pend_p[15:0] and pend_r[15:0] capture edges.
  - Set has priority over clear on the same bit in the same cycle.
  - Setting a bit that is already set and not being cleared that cycle loses an event and sets overflow.
- **Arbiter:** each cycle, if the FIFO can accept, select one pending event.
  - Any pend_p bit beats any pend_r bit; lowest index wins within each mask.
  - Push {release, code} and clear that pending bit.
  - Presses go first, so a key's press is always queued before its release.
- **FIFO can accept:** !full, or full with a pop this cycle (out_valid & out_ready).
- **Pop:** out_valid & out_ready.
- **Full FIFO:** events wait in the pending masks; nothing is lost unless a bit re-sets.
- **Reset:**
  - sync, prev, pending masks, FIFO pointers, overflow, out_valid, out_code, out_release and fifo_level are all 0.
  - overflow clears only on rst.
  - A key held through reset produces a press event after reset.

## Timing
- btn change sampled at edge k → s1 at k, s2 at k+1, pending set at k+2, FIFO write at k+3.
- out_valid is high after edge k+3 when the queue was empty: 4 edges of latency.
- First-word fall-through: out_code/out_release are valid while out_valid is high and stable until popped.
- Throughput: one push and one pop per cycle.
- Simultaneous push and pop leaves fifo_level unchanged, including when full.
- n simultaneous presses enqueue on n consecutive cycles, lowest index first.
- Reset asserted mid-operation discards queued and pending events immediately; outputs go to 0 asynchronously.

## Structure
- Package key_pkg:
  - NUM_KEYS=16, KEY_W=4.
  - key_event_t struct {release, code[3:0]}.
  - Function key_code(row, col) = row*4+col.
- Sub-module key_fifo:
  - Parameterised on DEPTH and a key_event_t payload.
  - Push/pop, full/empty, level, FWFT output.
  - Reused by later consumers.
- The top contains the synchroniser, edge detect, pending masks and fixed-priority arbiter.

## Test plan
- **Single press:** btn=0 → 0x0020 held, out_ready=1 → exactly one event {release=0, code=5}, 4 edges after sampling. Release → {1, 5} follows.
- **Simultaneous press:** btn 0 → 0x8101 in one cycle → events with codes 0, 8, 15 on consecutive cycles, all release=0.
- **Back-pressure:** out_ready=0, DEPTH=8, 10 distinct presses → fifo_level=8, overflow=0. Raising out_ready drains all 10 in index order.
- **Overflow:** out_ready=0 with FIFO full; press, release, press key 3 → overflow=1. The queue later holds a single press and a single release for key 3.
- **Release masking and reset:** REPORT_RELEASE=0 → releases produce no events. rst pulsed with 3 events queued → out_valid=0 and fifo_level=0 asynchronously; a key held through reset yields one press after rst falls.
